fifo_wr_ctrl: RTL

//  Write-domain pointer/flag controller for the asynchronous FIFO. Keeps the binary and Gray write pointers.

---
 rtl/fifo_pkg.sv | 23 ++
 rtl/fifo_bin2gray_reg.sv | 32 +++
 rtl/fifo_wr_ctrl.sv | 83 ++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared pointer helpers for both sides of the asynchronous FIFO.
// Provides the pointer-width helper and Gray/binary conversions.
package fifo_pkg;

    function automatic int ptr_w(input int addr_width);
        return addr_width + 1;
    endfunction

    // Operates on a zero-extended 32-bit word so any pointer width up to 32 can share it.
    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] gray);
        logic [31:0] bin;
        bin[31] = gray[31];
        for (int i = 30; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/fifo_bin2gray_reg.sv
// Binary pointer with increment and a registered Gray copy; shared by both FIFO pointer controllers.
// The Gray output is a flop so it cannot glitch into the opposite clock domain.
module fifo_bin2gray_reg
    import fifo_pkg::*;
#(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] bin,
    output logic [W-1:0] bin_next,
    output logic [W-1:0] gray_next,
    output logic [W-1:0] gray
);

    always_comb begin
        bin_next  = bin + W'(inc);
        gray_next = W'(bin2gray(32'(bin_next)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bin  <= '0;
            gray <= '0;
        end else begin
            bin  <= bin_next;
            gray <= gray_next;
        end
    end

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-side pointer and flag controller of the asynchronous FIFO.
// Optional almost_full comparator enabled by FIFO_ALMOST_FULL_EN; otherwise almost_full is tied low.
module fifo_wr_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int AF_THRESH  = 240
) (
    input  logic                  clk_wr,
    input  logic                  rst_wr,
    input  logic                  wr_en,
    output logic                  wr_fire,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [ADDR_WIDTH:0]   wr_ptr_gray,
    input  logic [ADDR_WIDTH:0]   rd_ptr_gray_sync,
    output logic                  full,
    output logic                  wr_ovf,
    output logic [ADDR_WIDTH:0]   wr_level,
    output logic                  almost_full
);

    localparam int PW = ptr_w(ADDR_WIDTH);

    if (ADDR_WIDTH < 2 || AF_THRESH < 0 || AF_THRESH > (1 << ADDR_WIDTH)) begin : g_bad_cfg
        $error("fifo_wr_ctrl: ADDR_WIDTH must be >= 2 and AF_THRESH within 0..depth");
    end

    logic [PW-1:0] wr_bin;
    logic [PW-1:0] wr_bin_next;
    logic [PW-1:0] wr_gray_next;
    logic [PW-1:0] rd_bin_sync;
    logic [PW-1:0] rd_gray_full;
    logic [PW-1:0] wr_level_next;
    logic          full_next;

    assign wr_fire = wr_en & ~full;
    assign wr_addr = wr_bin[ADDR_WIDTH-1:0];

    fifo_bin2gray_reg #(.W(PW)) u_wr_ptr (
        .clk       (clk_wr),
        .rst       (rst_wr),
        .inc       (wr_fire),
        .bin       (wr_bin),
        .bin_next  (wr_bin_next),
        .gray_next (wr_gray_next),
        .gray      (wr_ptr_gray)
    );

    // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted.
    always_comb begin
        rd_bin_sync   = PW'(gray2bin(32'(rd_ptr_gray_sync)));
        rd_gray_full  = {~rd_ptr_gray_sync[PW-1:PW-2], rd_ptr_gray_sync[PW-3:0]};
        full_next     = (wr_gray_next == rd_gray_full);
        wr_level_next = wr_bin_next - rd_bin_sync;
    end

    always_ff @(posedge clk_wr) begin
        if (rst_wr) begin
            full     <= 1'b0;
            wr_ovf   <= 1'b0;
            wr_level <= '0;
        end else begin
            full     <= full_next;
            wr_ovf   <= wr_en & full;
            wr_level <= wr_level_next;
        end
    end

`ifdef FIFO_ALMOST_FULL_EN
    localparam logic [PW-1:0] AF_LEVEL = PW'(AF_THRESH);

    always_ff @(posedge clk_wr) begin
        if (rst_wr) begin
            almost_full <= 1'b0;
        end else begin
            almost_full <= (wr_level_next >= AF_LEVEL);
        end
    end
`else
    assign almost_full = 1'b0;
`endif

endmodule
